// File: rtl/preg_pkg.sv
// preg_pkg
// Shared definitions for the P-register write/RMW arbiter:
//   PW       - default P-register width
//   OP_*     - requester opcodes (write, increment, decrement, add)
//   state_t  - arbiter FSM state encoding
package preg_pkg;

    localparam int PW = 12;

    localparam logic [1:0] OP_WR  = 2'b00;  // P := data
    localparam logic [1:0] OP_INC = 2'b01;  // P := P + 1
    localparam logic [1:0] OP_DEC = 2'b10;  // P := P - 1
    localparam logic [1:0] OP_ADD = 2'b11;  // P := P + data

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter
// Combinational round-robin selector. The search starts at requester `rr`
// and wraps around, so the requester at the pointer has highest priority.
// Ports:
//   req    in  NREQ  request vector
//   rr     in  IW    priority pointer (always < NREQ)
//   grant  out NREQ  one-hot grant (all zero when no request)
//   idx    out IW    index of the granted requester
//   any    out 1     at least one request present
module rr_arbiter #(
    parameter int NREQ = 3,
    parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   rr,
    output logic [NREQ-1:0] grant,
    output logic [IW-1:0]   idx,
    output logic            any
);

    always_comb begin
        int cand;
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        cand  = 0;
        for (int k = 0; k < NREQ; k++) begin
            // Rotate the search origin to the pointer; rr < NREQ so one
            // subtraction is enough to wrap.
            cand = int'(rr) + k;
            if (cand >= NREQ) begin
                cand = cand - NREQ;
            end
            if (!any && req[cand]) begin
                any         = 1'b1;
                idx         = IW'(cand);
                grant[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/preg_write_arbiter.sv
// preg_write_arbiter
// Shares the P-register file write port (pselw/wep/d12) and read port 1
// (psel1/qp1) among NREQ requesters. A granted request is either a plain
// write (IDLE -> WRITE) or a read-modify-write (IDLE -> READ -> WRITE).
// Grants rotate round-robin; the pointer advances past each completed winner.
// Ports:
//   clk, rst  clock and asynchronous active-high reset
//   req       per-requester request, held until its ack
//   op        per-requester opcode, slice i = op[2i+1:2i]
//   sel       per-requester target register, slice i = sel[2i+1:2i]
//   data      per-requester write value / addend, slice i = data[PW*i +: PW]
//   ack       one-hot completion pulse (WRITE cycle)
//   result    value written, meaningful in the ack cycle
//   busy      FSM outside IDLE
//   pselw     register-file write select
//   wep       register-file write enable
//   d12       register-file write data
//   psel1     register-file read port 1 select
//   qp1       register-file read port 1 data (combinational from psel1)
module preg_write_arbiter #(
    parameter int NREQ = 3,
    parameter int PW   = preg_pkg::PW
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [2*NREQ-1:0]    op,
    input  logic [2*NREQ-1:0]    sel,
    input  logic [PW*NREQ-1:0]   data,
    output logic [NREQ-1:0]      ack,
    output logic [PW-1:0]        result,
    output logic                 busy,
    output logic [1:0]           pselw,
    output logic                 wep,
    output logic [PW-1:0]        d12,
    output logic [1:0]           psel1,
    input  logic [PW-1:0]        qp1
);

    import preg_pkg::*;

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_t              state;
    state_t              state_nxt;
    logic [IW-1:0]       rr;
    logic [IW-1:0]       win_idx;
    logic [NREQ-1:0]     win_oh;
    logic [1:0]          op_l;
    logic [1:0]          sel_l;
    logic [PW-1:0]       wval;

    logic [NREQ-1:0]     gnt;
    logic [IW-1:0]       gnt_idx;
    logic                gnt_any;
    logic [1:0]          op_g;
    logic [1:0]          sel_g;
    logic [PW-1:0]       data_g;

    // Modulo-2^PW update; carry and borrow simply fall off the top.
    function automatic logic [PW-1:0] rmw_value(
        input logic [1:0]    opc,
        input logic [PW-1:0] cur,
        input logic [PW-1:0] addend
    );
        logic [PW-1:0] v;
        case (opc)
            OP_INC:  v = cur + PW'(1);
            OP_DEC:  v = cur - PW'(1);
            OP_ADD:  v = cur + addend;
            default: v = addend;
        endcase
        return v;
    endfunction

    function automatic logic [IW-1:0] next_rr(input logic [IW-1:0] cur);
        logic [IW-1:0] n;
        if (cur == IW'(NREQ - 1)) begin
            n = '0;
        end else begin
            n = cur + IW'(1);
        end
        return n;
    endfunction

    rr_arbiter #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_rr (
        .req   (req),
        .rr    (rr),
        .grant (gnt),
        .idx   (gnt_idx),
        .any   (gnt_any)
    );

    // Fields of the requester currently winning arbitration.
    always_comb begin
        int gi;
        gi     = int'(gnt_idx);
        op_g   = op[2*gi +: 2];
        sel_g  = sel[2*gi +: 2];
        data_g = data[PW*gi +: PW];
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (gnt_any) begin
                    state_nxt = (op_g == OP_WR) ? ST_WRITE : ST_READ;
                end
            end
            ST_READ:  state_nxt = ST_WRITE;
            ST_WRITE: state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // wval holds the raw data from grant until READ replaces it with the
    // modified value, so it doubles as the addend for ADD.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            rr      <= '0;
            win_idx <= '0;
            win_oh  <= '0;
            op_l    <= OP_WR;
            sel_l   <= '0;
            wval    <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                ST_IDLE: begin
                    if (gnt_any) begin
                        win_idx <= gnt_idx;
                        win_oh  <= gnt;
                        op_l    <= op_g;
                        sel_l   <= sel_g;
                        wval    <= data_g;
                    end
                end
                ST_READ: begin
                    wval <= rmw_value(op_l, qp1, wval);
                end
                ST_WRITE: begin
                    rr <= next_rr(win_idx);
                end
                default: begin
                end
            endcase
        end
    end

    // Outputs decode straight from state so reset removes wep/ack at once.
    assign wep    = (state == ST_WRITE);
    assign busy   = (state != ST_IDLE);
    assign ack    = (state == ST_WRITE) ? win_oh : '0;
    assign result = wval;
    assign d12    = wval;
    assign pselw  = sel_l;
    assign psel1  = sel_l;

endmodule

// File: tb/tb_preg_write_arbiter.sv
module tb_preg_write_arbiter;

    localparam int NREQ = 3;
    localparam int PW   = 12;

    localparam logic [1:0] WR  = 2'b00;
    localparam logic [1:0] INC = 2'b01;
    localparam logic [1:0] DEC = 2'b10;
    localparam logic [1:0] ADD = 2'b11;

    logic                clk = 1'b0;
    logic                rst;
    logic [NREQ-1:0]     req_v;
    logic [2*NREQ-1:0]   op_v;
    logic [2*NREQ-1:0]   sel_v;
    logic [PW*NREQ-1:0]  data_v;
    logic [NREQ-1:0]     ack;
    logic [PW-1:0]       result;
    logic                busy;
    logic [1:0]          pselw;
    logic                wep;
    logic [PW-1:0]       d12;
    logic [1:0]          psel1;
    logic [PW-1:0]       qp1;

    // Register-file model with a preload path for setting up test values.
    logic [PW-1:0]       pr [0:3];
    logic                ld_en;
    logic [1:0]          ld_sel;
    logic [PW-1:0]       ld_val;

    typedef struct {
        int            idx;
        logic [PW-1:0] res;
        int            lat;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ld_en) begin
            pr[ld_sel] <= ld_val;
        end else if (wep) begin
            pr[pselw] <= d12;
        end
    end

    assign qp1 = pr[psel1];

    preg_write_arbiter #(
        .NREQ (NREQ),
        .PW   (PW)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .req    (req_v),
        .op     (op_v),
        .sel    (sel_v),
        .data   (data_v),
        .ack    (ack),
        .result (result),
        .busy   (busy),
        .pselw  (pselw),
        .wep    (wep),
        .d12    (d12),
        .psel1  (psel1),
        .qp1    (qp1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic preload(input logic [1:0] s, input logic [PW-1:0] v);
        ld_sel = s;
        ld_val = v;
        ld_en  = 1'b1;
        @(negedge clk);
        ld_en  = 1'b0;
    endtask

    task automatic issue(input int i, input logic [1:0] o, input logic [1:0] s,
                         input logic [PW-1:0] d);
        req_v[i]           = 1'b1;
        op_v[2*i +: 2]     = o;
        sel_v[2*i +: 2]    = s;
        data_v[PW*i +: PW] = d;
    endtask

    // Waits (bounded) for the next ack, compares it with the oldest
    // scoreboard entry, releases the requesters in drop, then checks that
    // the write strobe lasted a single cycle.
    task automatic wait_ack(input logic [NREQ-1:0] drop);
        exp_t            e;
        int              c;
        bit              seen;
        logic [NREQ-1:0] exp_oh;
        e    = sb.pop_front();
        c    = 0;
        seen = 1'b0;
        while (!seen && c < 12) begin
            @(negedge clk);
            c++;
            if (ack != '0) seen = 1'b1;
        end
        exp_oh = 3'b001 << e.idx;
        check("ack_onehot", 32'(ack), 32'(exp_oh));
        check("result", 32'(result), 32'(e.res));
        check("wep_in_ack", 32'(wep), 32'd1);
        check("latency", 32'(c), 32'(e.lat));
        req_v = req_v & ~drop;
        @(negedge clk);
        check("wep_one_cycle", 32'(wep), 32'd0);
        check("ack_one_cycle", 32'(ack), 32'd0);
    endtask

    initial begin
        rst    = 1'b1;
        req_v  = '0;
        op_v   = '0;
        sel_v  = '0;
        data_v = '0;
        ld_en  = 1'b0;
        ld_sel = '0;
        ld_val = '0;
        repeat (2) @(negedge clk);

        check("rst_ack", 32'(ack), 32'd0);
        check("rst_wep", 32'(wep), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_d12", 32'(d12), 32'd0);
        check("rst_pselw", 32'(pselw), 32'd0);
        check("rst_psel1", 32'(psel1), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Round robin: all three hold WR requests; order must be 0,1,2,0,1,2.
        issue(0, WR, 2'd0, 12'h100);
        issue(1, WR, 2'd1, 12'h101);
        issue(2, WR, 2'd2, 12'h102);
        for (int k = 0; k < 6; k++) sb.push_back('{k % 3, 12'(12'h100 + (k % 3)), 1});
        for (int k = 0; k < 5; k++) wait_ack(3'b000);
        wait_ack(3'b111);
        check("rr_p0", 32'(pr[0]), 32'h100);
        check("rr_p2", 32'(pr[2]), 32'h102);

        // Single WR.
        issue(0, WR, 2'd2, 12'hAAA);
        sb.push_back('{0, 12'hAAA, 1});
        wait_ack(3'b001);
        check("wr_p2", 32'(pr[2]), 32'hAAA);

        // RMW wrap cases on P1.
        preload(2'd1, 12'hFFF);
        issue(1, INC, 2'd1, 12'h000);
        sb.push_back('{1, 12'h000, 2});
        wait_ack(3'b010);
        check("inc_wrap_p1", 32'(pr[1]), 32'h000);
        issue(1, DEC, 2'd1, 12'h000);
        sb.push_back('{1, 12'hFFF, 2});
        wait_ack(3'b010);
        check("dec_wrap_p1", 32'(pr[1]), 32'hFFF);
        issue(1, ADD, 2'd1, 12'h002);
        sb.push_back('{1, 12'h001, 2});
        wait_ack(3'b010);
        check("add_wrap_p1", 32'(pr[1]), 32'h001);

        // Back-to-back dependency on P3 (pointer at 2, so requester 0 first).
        preload(2'd3, 12'h555);
        issue(0, INC, 2'd3, 12'h000);
        issue(1, ADD, 2'd3, 12'h111);
        sb.push_back('{0, 12'h556, 2});
        sb.push_back('{1, 12'h667, 2});
        wait_ack(3'b001);
        wait_ack(3'b010);
        check("dep_p3", 32'(pr[3]), 32'h667);

        // Late change of inputs during READ must not affect the operation.
        preload(2'd1, 12'h100);
        issue(2, ADD, 2'd1, 12'h010);
        sb.push_back('{2, 12'h110, 1});
        @(negedge clk);
        check("late_busy_read", 32'(busy), 32'd1);
        check("late_no_ack_read", 32'(ack), 32'd0);
        op_v[5:4]    = WR;
        sel_v[5:4]   = 2'd3;
        data_v[35:24] = 12'hFFF;
        wait_ack(3'b100);
        check("late_p1", 32'(pr[1]), 32'h110);
        check("late_p3_untouched", 32'(pr[3]), 32'h667);

        // Move the pointer off zero, then abort an INC with reset.
        issue(1, WR, 2'd2, 12'h777);
        sb.push_back('{1, 12'h777, 1});
        wait_ack(3'b010);
        preload(2'd0, 12'h123);
        issue(0, INC, 2'd0, 12'h000);
        @(negedge clk);
        check("abort_busy_read", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        check("abort_wep", 32'(wep), 32'd0);
        check("abort_ack", 32'(ack), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        req_v = '0;
        repeat (2) begin
            @(negedge clk);
            check("abort_hold_wep", 32'(wep), 32'd0);
        end
        rst = 1'b0;
        @(negedge clk);
        check("abort_p0", 32'(pr[0]), 32'h123);
        check("abort_busy_after", 32'(busy), 32'd0);

        // Pointer back at 0: requester 0 must beat requester 2.
        issue(0, WR, 2'd0, 12'h0AB);
        issue(2, WR, 2'd2, 12'h0CD);
        sb.push_back('{0, 12'h0AB, 1});
        sb.push_back('{2, 12'h0CD, 1});
        wait_ack(3'b001);
        wait_ack(3'b100);
        check("post_rst_p0", 32'(pr[0]), 32'h0AB);
        check("post_rst_p2", 32'(pr[2]), 32'h0CD);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/preg_write_arbiter.md
# preg_write_arbiter

Shares the single P-register write port (pselw/wep/d12) and read port 1 (psel1/qp1) of the io881 pointer register file among NREQ requesters. Each granted request is a plain write or a read-modify-write (increment, decrement, add), sequenced by a small FSM with round-robin fairness. Sits between the execute/address units and the register file; port 0 stays with the instruction datapath.

## Interface
- NREQ, 3: number of requesters (2..4)
- PW, 12: P-register width
- clk  in  1  system clock; all state on posedge
- rst  in  1  asynchronous, active-high reset
- req  in  NREQ  request per requester; held until its ack
- op  in  2*NREQ  opcode per requester (slice i = bits 2i+1:2i)
- sel  in  2*NREQ  target P register per requester
- data  in  PW*NREQ  write value / addend per requester
- ack  out  NREQ  one-cycle completion pulse, one-hot
- result  out  PW  value written; valid only in the ack cycle
- busy  out  1  FSM not in IDLE
- pselw  out  2  register-file write select
- wep  out  1  register-file write enable (write on posedge while high)
- d12  out  PW  register-file write data
- psel1  out  2  register-file read port 1 select
- qp1  in  PW  register-file read port 1 data (combinational from psel1)

## Operation
- Opcodes: WR=00 (P := data), INC=01 (P := P+1), DEC=10 (P := P-1), ADD=11 (P := P+data). Arithmetic modulo 2^PW; carry/borrow discarded (FFF+1=000, 000-1=FFF).
- States: IDLE, READ, WRITE.
- IDLE: if any req, pick winner by round-robin from priority pointer rr; latch winner index, op, sel, data. WR -> WRITE with latched data as write value; else -> READ.
- READ: psel1 = latched sel; latch computed value from qp1 -> WRITE.
- WRITE: pselw = latched sel, d12 = write value, wep = 1, ack[winner] = 1, result = write value; rr := winner+1 mod NREQ -> IDLE.
- Requests are sampled only in IDLE; op/sel/data changes after grant are ignored.
- A requester still asserting req in the cycle after its ack is a new request and competes normally.
- rr after reset = 0 (requester 0 highest priority).
- Idle outputs: wep=0, ack=0, pselw=psel1=latched sel (no glitching required but wep must be 0).

## Timing
- Reset values: ack=0, wep=0, busy=0, result=0, d12=0, pselw=0, psel1=0, state=IDLE, rr=0.
- Reset asserted mid-operation: wep and ack drop immediately (async); no write occurs; pending request lost, requester must retry.
- WR latency: req seen in IDLE at edge n -> wep/ack high during cycle n+1 -> register updated at edge n+2.
- RMW latency: READ during cycle n+1, wep/ack during cycle n+2; throughput one op per 2 (WR) or 3 (RMW) cycles.
- qp1 sampled at the end of READ; read-after-write to the same register across consecutive grants sees the new value (write precedes next READ by ≥1 edge).
- busy high in READ and WRITE.

## Structure
- Shared package preg_pkg: PW, opcode constants (OP_WR/OP_INC/OP_DEC/OP_ADD), state encoding.
- Sub-module rr_arbiter (NREQ-wide, req vector + rr pointer in, one-hot grant + index out, combinational); FSM, latches and adder in preg_write_arbiter.

## Test plan
- Single WR: req0, op=WR, sel=2, data=AAA -> ack0 one cycle later, wep for one cycle, P2 reads AAA on qp0.
- RMW wrap: P1=FFF, req1 INC sel=1 -> ack1 two cycles after grant, result=000; then DEC -> FFF; ADD data=002 on P1=FFF -> 001.
- Round-robin: req0,1,2 held continuously with WR -> acks in order 0,1,2,0,1,2; no requester granted twice before others.
- Back-to-back dependency: req0 INC P3 (P3=555) then req1 ADD P3 data=111 -> P3=667, results 556 then 667.
- Reset mid-op: assert rst during READ of INC on P0=123 -> wep/ack never assert, P0 remains 123, rr=0, busy=0 after release.
- Late change: alter data/sel of granted requester during READ -> written value uses latched inputs.
